// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encodings,
// handshake constants and the operand magnitude helper.
package div_unit_pkg;

  typedef logic [1:0] div_state_t;

  // FSM state encodings
  localparam div_state_t DIV_FREE   = 2'b00;
  localparam div_state_t DIV_BYZERO = 2'b01;
  localparam div_state_t DIV_ON     = 2'b10;
  localparam div_state_t DIV_END    = 2'b11;

  // Handshake levels shared with the EX stage
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;

  // Number of restoring-division iterations
  localparam logic [5:0] DIV_ITERATIONS = 6'd32;

  // Magnitude of an operand: two's complement negated only when the
  // operation is signed and the operand is negative. 0x80000000 maps to
  // itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] operand_magnitude(input logic [31:0] x,
                                                    input logic        is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative 32-bit signed/unsigned divider, one quotient bit per cycle.
// Result is {remainder, quotient} and is held until EX drops start_i.
module div_unit
  import div_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_t  state;
  logic [5:0]  cnt;
  logic [64:0] work;
  logic [31:0] divisor;
  logic        neg_quot;
  logic        neg_rem;

  logic [32:0] trial;
  logic [31:0] quot_fixed;
  logic [31:0] rem_fixed;

  // Trial subtraction of the divisor from the current partial remainder,
  // plus the final sign corrections applied on the last cycle of ON.
  always_comb begin
    trial      = {1'b0, work[63:32]} - {1'b0, divisor};
    quot_fixed = neg_quot ? (~work[31:0] + 32'd1) : work[31:0];
    rem_fixed  = neg_rem  ? (~work[64:33] + 32'd1) : work[64:33];
  end

  // Divider FSM, datapath and registered result/ready outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_FREE;
      cnt      <= 6'd0;
      work     <= 65'd0;
      divisor  <= 32'd0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          result_o <= 64'd0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (start_i == DIV_START && !annul_i) begin
            if (opdata2_i == 32'd0) begin
              state <= DIV_BYZERO;
            end else begin
              state    <= DIV_ON;
              cnt      <= 6'd0;
              work     <= {32'd0, operand_magnitude(opdata1_i, signed_div_i), 1'b0};
              divisor  <= operand_magnitude(opdata2_i, signed_div_i);
              // Capture sign corrections now; operands may change later.
              neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
              neg_rem  <= signed_div_i & opdata1_i[31];
            end
          end
        end

        DIV_BYZERO: begin
          result_o <= 64'd0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (annul_i) begin
            state <= DIV_FREE;
          end else begin
            work  <= 65'd0;
            state <= DIV_END;
          end
        end

        DIV_ON: begin
          result_o <= 64'd0;
          ready_o  <= DIV_RESULT_NOT_READY;
          if (annul_i) begin
            state <= DIV_FREE;
            cnt   <= 6'd0;
          end else if (cnt != DIV_ITERATIONS) begin
            // Restoring step: keep the shifted remainder if the trial went
            // negative, otherwise commit the difference and set a 1 bit.
            if (trial[32]) begin
              work <= {work[63:0], 1'b0};
            end else begin
              work <= {trial[31:0], work[31:0], 1'b1};
            end
            cnt <= cnt + 6'd1;
          end else begin
            work  <= {rem_fixed, work[32], quot_fixed};
            state <= DIV_END;
            cnt   <= 6'd0;
          end
        end

        DIV_END: begin
          // annul_i is ignored here; only EX dropping start_i releases END.
          if (start_i == DIV_START) begin
            result_o <= {work[64:33], work[31:0]};
            ready_o  <= DIV_RESULT_READY;
          end else begin
            result_o <= 64'd0;
            ready_o  <= DIV_RESULT_NOT_READY;
            state    <= DIV_FREE;
          end
        end

        default: begin
          state    <= DIV_FREE;
          result_o <= 64'd0;
          ready_o  <= DIV_RESULT_NOT_READY;
        end
      endcase
    end
  end

endmodule
